ssp_uart_sched: RTL and testbench
=================================

// Module: ssp_uart_sched
// PURPOSE
// Round-robin scheduler sharing the single SSP register port of ssp_uart between NREQ requesters.
// Each granted request becomes exactly one SSP frame: SSEL window, RA/WnR/DI held stable, EOC on last cycle.
// Read data (SSP_DO) is captured at EOC and returned with a one-cycle ack. Sits between host agents and ssp_uart.
// PARAMETERS
// NREQ      2  number of requesters (2..8)
// FRAME_LEN 4  cycles SSP_SSEL is high per frame (>=2); EOC on the last one
// IDLE_GAP  1  cycles SSP_SSEL is forced low between frames (>=1)
// PORTS
// Clk        in   1         system clock, all state on rising edge
// Rst_n      in   1         asynchronous, active-low reset
// req        in   NREQ      request per requester; held high until its ack
// req_ra     in   NREQ*3    register address per requester (UCR=0,USR=1,TDR=2,RDR=3,SPR=4)
// req_wnr    in   NREQ      1=write, 0=read
// req_di     in   NREQ*12   write data per requester
// ack        out  NREQ      one-cycle completion pulse, one-hot
// err        out  NREQ      valid with ack: 1 = address rejected, no frame issued
// rdata      out  12        read data, valid with ack
// busy       out  1         high from grant until end of gap
// SSP_SSEL   out  1         frame select to ssp_uart
// SSP_RA     out  3         register address to ssp_uart
// SSP_WnR    out  1         write/read to ssp_uart
// SSP_DI     out  12        write data to ssp_uart
// SSP_EOC    out  1         end-of-cycle strobe to ssp_uart
// SSP_DO     in   12        read data from ssp_uart
// BEHAVIOUR
// - Reset (Rst_n=0, async): all outputs 0, state IDLE, rr pointer 0, no pending ack; in-flight frame aborted, not retried.
// - All outputs are registered. Outside FRAME: SSP_SSEL=SSP_EOC=0, SSP_RA=0, SSP_WnR=0, SSP_DI=0.
// - States: IDLE -> FRAME -> RESP -> GAP -> IDLE; IDLE -> RESP on rejected address.
// - IDLE: arbitrate only here. Grant = first req[i] with req high, searching from ptr, ptr+1, ... wrapping at NREQ.
//   ptr := granted+1 (mod NREQ) at grant. Granted req_ra/wnr/di latched at the grant edge; later changes ignored.
// - Address check: req_ra > 3'b100 -> no frame; next cycle RESP with ack[g]=1, err[g]=1, rdata=0.
// - FRAME: cycle counter 0..FRAME_LEN-1; SSP_SSEL=1, RA/WnR/DI = latched values for all FRAME_LEN cycles;
//   SSP_EOC=1 only when counter==FRAME_LEN-1. SSP_DO sampled on the edge ending that cycle (reads only).
// - RESP (1 cycle): ack[g]=1, err[g]=0; rdata = captured SSP_DO for reads, 12'h000 for writes. rdata holds until next ack.
// - GAP: IDLE_GAP cycles, SSEL low, busy high; then IDLE.
// - Latency, grant edge T: SSEL high in cycles T+1..T+FRAME_LEN; ack in cycle T+FRAME_LEN+1; next grant no earlier than
//   T+FRAME_LEN+IDLE_GAP+2.
// - A requester may keep req high after ack; this counts as a new request and competes normally (rr ensures fairness).
// - req dropped before ack: protocol violation; latched transaction still completes and acks.
// - No requests: stay IDLE, busy=0. At most one ack bit high per cycle; never ack without a prior grant.
// STRUCTURE
// - ssp_uart_pkg: register address constants (UCR,USR,TDR,RDR,SPR), SSP_AW=3, SSP_DW=12,
//   state enum sched_state_e {IDLE,FRAME,RESP,GAP}.
// - Sub-module ssp_rr_arbiter #(NREQ): combinational one-hot grant from req and ptr.
//   Pointer register, FSM and counters stay in ssp_uart_sched.
// TESTING
// - req0 write UCR 12'hDED, FRAME_LEN=4 -> SSEL high 4 cycles, EOC only on 4th, ack[0] next cycle, err=0, rdata=0.
//   Following read of UCR -> rdata=12'hDED.
// - Reads of UCR,USR,TDR,RDR,SPR straight after reset -> each ack with rdata=12'h000.
// - req0 and req1 both held high continuously -> grants alternate 0,1,0,1. Frames never overlap.
//   Gap >= IDLE_GAP between SSEL windows.
// - req1 read with req_ra=3'h7 -> ack[1]=1, err[1]=1 one cycle after grant; SSEL never asserted.
// - Five back-to-back TDR writes 12'h0F1..12'h0F5 from req0 -> five frames in order, SSP_DI matches each, five acks.
// - Rst_n low in 2nd FRAME cycle -> SSEL/EOC/ack drop immediately; after release, IDLE with ptr=0, pending req regranted.

Source files
------------

// File: rtl/ssp_uart_pkg.sv
// Shared constants and types for the ssp_uart register-port scheduler.
package ssp_uart_pkg;

  localparam int SSP_AW = 3;
  localparam int SSP_DW = 12;

  // ssp_uart register map; anything above SPR is rejected without a frame
  localparam logic [SSP_AW-1:0] UCR = 3'd0;
  localparam logic [SSP_AW-1:0] USR = 3'd1;
  localparam logic [SSP_AW-1:0] TDR = 3'd2;
  localparam logic [SSP_AW-1:0] RDR = 3'd3;
  localparam logic [SSP_AW-1:0] SPR = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    RESP  = 2'd2,
    GAP   = 2'd3
  } sched_state_e;

endpackage

// File: rtl/ssp_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first active
// request at or above ptr, wrapping to the lowest active request below it.
module ssp_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt
);

  logic [NREQ-1:0] hi_mask;
  logic [NREQ-1:0] hi_req;

  // Prefer requests at positions >= ptr; otherwise fall back to the lowest one.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      hi_mask[i] = (i >= int'(ptr));
    end
    hi_req = req & hi_mask;
    if (|hi_req) begin
      gnt = hi_req & (~hi_req + NREQ'(1));
    end else begin
      gnt = req & (~req + NREQ'(1));
    end
  end

endmodule

// File: rtl/ssp_uart_sched.sv
// Round-robin scheduler sharing the single ssp_uart register port among
// NREQ requesters. One grant becomes one SSP frame (or an immediate error
// response for an out-of-range address), followed by a one-cycle ack and
// an idle gap. Handshake: a requester raises req with its ra/wnr/di and
// keeps req high until it sees its one-cycle ack; the transaction fields
// are captured at the grant edge, so they may change freely afterwards.
module ssp_uart_sched
  import ssp_uart_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int FRAME_LEN = 4,
  parameter int IDLE_GAP  = 1
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*SSP_AW-1:0] req_ra,
  input  logic [NREQ-1:0]        req_wnr,
  input  logic [NREQ*SSP_DW-1:0] req_di,
  output logic [NREQ-1:0]        ack,
  output logic [NREQ-1:0]        err,
  output logic [SSP_DW-1:0]      rdata,
  output logic                   busy,
  output logic                   SSP_SSEL,
  output logic [SSP_AW-1:0]      SSP_RA,
  output logic                   SSP_WnR,
  output logic [SSP_DW-1:0]      SSP_DI,
  output logic                   SSP_EOC,
  input  logic [SSP_DW-1:0]      SSP_DO,
  output sched_state_e           dbg_state
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(FRAME_LEN + IDLE_GAP + 1);

  sched_state_e      state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic [SSP_DW-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              ssel_q, ssel_d;
  logic [SSP_AW-1:0] ra_q, ra_d;
  logic              wnr_q, wnr_d;
  logic [SSP_DW-1:0] di_q, di_d;
  logic              eoc_q, eoc_d;

  logic [NREQ-1:0]   gnt;
  logic [PW-1:0]     gidx;
  logic [SSP_AW-1:0] sel_ra;
  logic              sel_wnr;
  logic [SSP_DW-1:0] sel_di;

  ssp_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  // Decode the one-hot grant into an index and the granted requester's fields.
  always_comb begin
    gidx    = '0;
    sel_ra  = '0;
    sel_wnr = 1'b0;
    sel_di  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gidx    = PW'(i);
        sel_ra  = req_ra[i*SSP_AW +: SSP_AW];
        sel_wnr = req_wnr[i];
        sel_di  = req_di[i*SSP_DW +: SSP_DW];
      end
    end
  end

  // Next-state logic; every output is computed here and registered below.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    ssel_d  = ssel_q;
    ra_d    = ra_q;
    wnr_d   = wnr_q;
    di_d    = di_q;
    eoc_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          ptr_d  = (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);
          gnt_d  = gnt;
          busy_d = 1'b1;
          cnt_d  = '0;
          if (sel_ra > SPR) begin
            // Bad address: answer straight away, the SSP port is never touched.
            state_d = RESP;
            ack_d   = gnt;
            err_d   = gnt;
            rdata_d = '0;
          end else begin
            state_d = FRAME;
            ssel_d  = 1'b1;
            ra_d    = sel_ra;
            wnr_d   = sel_wnr;
            di_d    = sel_di;
          end
        end
      end
      FRAME: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(FRAME_LEN-2)) begin
          eoc_d = 1'b1;
        end
        if (cnt_q == CW'(FRAME_LEN-1)) begin
          // EOC cycle ends here: capture read data and drop the bus.
          state_d = RESP;
          ack_d   = gnt_q;
          rdata_d = wnr_q ? '0 : SSP_DO;
          cnt_d   = '0;
          ssel_d  = 1'b0;
          ra_d    = '0;
          wnr_d   = 1'b0;
          di_d    = '0;
        end
      end
      RESP: begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(IDLE_GAP-1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      ssel_q  <= 1'b0;
      ra_q    <= '0;
      wnr_q   <= 1'b0;
      di_q    <= '0;
      eoc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      ssel_q  <= ssel_d;
      ra_q    <= ra_d;
      wnr_q   <= wnr_d;
      di_q    <= di_d;
      eoc_q   <= eoc_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign SSP_SSEL  = ssel_q;
  assign SSP_RA    = ra_q;
  assign SSP_WnR   = wnr_q;
  assign SSP_DI    = di_q;
  assign SSP_EOC   = eoc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ssp_uart_sched.sv
// Bench for ssp_uart_sched: table-driven single transactions, hand-written
// multi-cycle sequences, and randomized traffic checked by a transaction
// level reference model (round-robin rule, frame shape, register memory).
module tb_ssp_uart_sched;
  import ssp_uart_pkg::*;

  localparam int NREQ = 2;
  localparam int FL   = 4;
  localparam int IG   = 1;

  // ---------------- clock / reset ----------------
  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  initial forever #5 Clk = ~Clk;

  logic [NREQ-1:0]        req     = '0;
  logic [NREQ*SSP_AW-1:0] req_ra  = '0;
  logic [NREQ-1:0]        req_wnr = '0;
  logic [NREQ*SSP_DW-1:0] req_di  = '0;
  logic [NREQ-1:0]        ack, err;
  logic [SSP_DW-1:0]      rdata, SSP_DI, SSP_DO;
  logic                   busy, SSP_SSEL, SSP_WnR, SSP_EOC;
  logic [SSP_AW-1:0]      SSP_RA;
  sched_state_e           dbg_state;

  ssp_uart_sched #(.NREQ(NREQ), .FRAME_LEN(FL), .IDLE_GAP(IG)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .req(req), .req_ra(req_ra), .req_wnr(req_wnr),
    .req_di(req_di), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .SSP_SSEL(SSP_SSEL), .SSP_RA(SSP_RA), .SSP_WnR(SSP_WnR), .SSP_DI(SSP_DI),
    .SSP_EOC(SSP_EOC), .SSP_DO(SSP_DO), .dbg_state(dbg_state)
  );

  // Simple register-file stand-in for ssp_uart.
  logic [SSP_DW-1:0] slv_mem [8];
  initial for (int i = 0; i < 8; i++) slv_mem[i] = '0;
  always @(posedge Clk) if (SSP_SSEL && SSP_EOC && SSP_WnR) slv_mem[SSP_RA] <= SSP_DI;
  assign SSP_DO = slv_mem[SSP_RA];

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got no/unexpected event, expected a legal one", nm);
  endtask

  typedef struct packed {
    logic [2:0]        g;
    logic [SSP_AW-1:0] ra;
    logic              wnr;
    logic [SSP_DW-1:0] di;
  } txn_t;

  txn_t              exp_q[$];
  logic [2:0]        gnt_log[$];
  logic [SSP_DW-1:0] di_log[$];
  logic [SSP_DW-1:0] mem_model [8];

  int                     cyc = 0, mptr = 0, grant_cyc = 0, last_ack_cyc = -100;
  int                     frame_cyc = 0, gap_cnt = 0, g = 0;
  bit                     seen_frame = 0, found = 0, e_err = 0;
  logic                   prev_busy = 0, prev_ssel = 0;
  logic [NREQ-1:0]        prev_req = '0, prev_wnr = '0;
  logic [NREQ*SSP_AW-1:0] prev_ra = '0;
  logic [NREQ*SSP_DW-1:0] prev_di = '0;
  logic [SSP_DW-1:0]      e_rd;
  txn_t                   t, h;

  // Reference model: observes grants, frames and acks at transaction level.
  initial begin
    for (int i = 0; i < 8; i++) mem_model[i] = '0;
    forever begin
      @(negedge Clk);
      cyc++;
      if (!Rst_n) begin
        exp_q.delete();
        mptr = 0; prev_ssel = 0; frame_cyc = 0; gap_cnt = 0;
        seen_frame = 0; last_ack_cyc = -100;
      end else begin
        if (busy && !prev_busy) begin
          found = 0; g = 0;
          for (int k = 0; k < NREQ; k++) begin
            if (!found && ((prev_req >> ((mptr + k) % NREQ)) & 1) != 0) begin
              found = 1; g = (mptr + k) % NREQ;
            end
          end
          if (!found) fail("grant_without_req");
          else begin
            t.g = 3'(g);
            t.ra = prev_ra[g*SSP_AW +: SSP_AW];
            t.wnr = prev_wnr[g];
            t.di = prev_di[g*SSP_DW +: SSP_DW];
            exp_q.push_back(t);
            gnt_log.push_back(3'(g));
            mptr = (g + 1) % NREQ;
            check("grant_spacing", 64'(cyc - last_ack_cyc >= IG + 2), 1);
            grant_cyc = cyc;
          end
        end
        if (!busy && !prev_busy && prev_req != 0) fail("missed_grant");

        if (SSP_SSEL) begin
          frame_cyc++;
          if (frame_cyc == 1 && seen_frame) check("gap_len_ok", 64'(gap_cnt >= IG), 1);
          if (exp_q.size() == 0) fail("ssel_without_grant");
          else begin
            h = exp_q[0];
            check("frame_for_valid_ra", 64'(h.ra <= SPR), 1);
            check("ssp_fields", {SSP_RA, SSP_WnR, SSP_DI}, {h.ra, h.wnr, h.di});
          end
          check("ssp_eoc", SSP_EOC, 64'(frame_cyc == FL));
          if (SSP_EOC) di_log.push_back(SSP_DI);
        end else begin
          check("idle_bus", {SSP_RA, SSP_WnR, SSP_DI, SSP_EOC}, 0);
          if (prev_ssel) begin
            check("frame_len", 64'(frame_cyc), FL);
            seen_frame = 1;
            gap_cnt = 0;
          end
          gap_cnt++;
          frame_cyc = 0;
        end

        if (ack != 0) begin
          check("ack_onehot", 64'($onehot(ack)), 1);
          if (exp_q.size() == 0) fail("ack_without_grant");
          else begin
            h = exp_q.pop_front();
            e_err = (h.ra > SPR);
            e_rd = (e_err || h.wnr) ? '0 : mem_model[h.ra];
            check("ack_vec", ack, 64'(1) << h.g);
            check("err_vec", err, e_err ? (64'(1) << h.g) : 0);
            check("rdata", rdata, e_rd);
            check("ack_latency", 64'(cyc - grant_cyc), e_err ? 0 : FL);
            if (!e_err && h.wnr) mem_model[h.ra] = h.di;
            last_ack_cyc = cyc;
          end
        end
      end
      prev_busy = busy; prev_ssel = SSP_SSEL;
      prev_req = req; prev_ra = req_ra; prev_wnr = req_wnr; prev_di = req_di;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_fields(input int i, input logic [2:0] ra, input logic w, input logic [11:0] d);
    req_ra[i*SSP_AW +: SSP_AW] = ra;
    req_wnr[i] = w;
    req_di[i*SSP_DW +: SSP_DW] = d;
  endtask

  task automatic rand_fields(input int i);
    set_fields(i, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)));
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge Clk);
      if (!busy) done = 1;
    end
    if (!done) fail("idle_timeout");
  endtask

  typedef struct {
    int          r;
    logic [2:0]  ra;
    logic        wnr;
    logic [11:0] di;
    logic        e_err;
    logic [11:0] e_rd;
  } vec_t;

  task automatic do_txn(input vec_t v);
    bit got;
    got = 0;
    @(posedge Clk); #1;
    set_fields(v.r, v.ra, v.wnr, v.di);
    req[v.r] = 1'b1;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge Clk);
      if (ack[v.r]) got = 1;
    end
    if (!got) fail("tbl_ack_timeout");
    else begin
      check("tbl_ack", ack, 64'(1) << v.r);
      check("tbl_err", err[v.r], v.e_err);
      check("tbl_rdata", rdata, v.e_rd);
    end
    @(posedge Clk); #1;
    req[v.r] = 1'b0;
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  vec_t tbl[11];
  int   n;
  bit   got;

  initial begin
    tbl[0]  = '{0, UCR,  1'b0, 12'h000, 1'b0, 12'h000};
    tbl[1]  = '{1, USR,  1'b0, 12'h000, 1'b0, 12'h000};
    tbl[2]  = '{0, TDR,  1'b0, 12'h000, 1'b0, 12'h000};
    tbl[3]  = '{1, RDR,  1'b0, 12'h000, 1'b0, 12'h000};
    tbl[4]  = '{0, SPR,  1'b0, 12'h000, 1'b0, 12'h000};
    tbl[5]  = '{0, UCR,  1'b1, 12'hDED, 1'b0, 12'h000};
    tbl[6]  = '{0, UCR,  1'b0, 12'h000, 1'b0, 12'hDED};
    tbl[7]  = '{1, 3'h7, 1'b0, 12'h000, 1'b1, 12'h000};
    tbl[8]  = '{1, 3'h5, 1'b1, 12'hABC, 1'b1, 12'h000};
    tbl[9]  = '{1, SPR,  1'b1, 12'h123, 1'b0, 12'h000};
    tbl[10] = '{0, SPR,  1'b0, 12'h000, 1'b0, 12'h123};

    // Reset values
    repeat (3) @(negedge Clk);
    check("reset_outputs", {ack, err, rdata, busy, SSP_SSEL, SSP_RA, SSP_WnR, SSP_DI, SSP_EOC}, 0);
    check("reset_state", dbg_state, IDLE);
    #1 Rst_n = 1'b1;
    repeat (3) @(negedge Clk);
    check("idle_no_req_busy", busy, 0);

    for (int k = 0; k < 11; k++) do_txn(tbl[k]);

    // Both requesters held high: grants must alternate.
    gnt_log.delete();
    @(posedge Clk); #1;
    set_fields(0, USR, 1'b0, 12'h000);
    set_fields(1, SPR, 1'b0, 12'h000);
    req = 2'b11;
    n = 0;
    for (int c = 0; c < 200 && n < 6; c++) begin
      @(posedge Clk); #1;
      if (ack != 0) n++;
    end
    req = '0;
    if (n < 6) fail("alt_timeout");
    wait_idle();
    check("alt_count", gnt_log.size(), 6);
    for (int k = 1; k < 6 && k < gnt_log.size(); k++)
      check("alt_order", gnt_log[k], (gnt_log[0] + 3'(k)) % 2);

    // Five back-to-back TDR writes from requester 0.
    di_log.delete();
    @(posedge Clk); #1;
    set_fields(0, TDR, 1'b1, 12'h0F1);
    req[0] = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < 5; c++) begin
      @(posedge Clk); #1;
      if (ack[0]) begin
        n++;
        if (n == 5) req[0] = 1'b0;
        else req_di[11:0] = 12'(12'h0F1 + n);
      end
    end
    req[0] = 1'b0;
    if (n < 5) fail("tdr_timeout");
    wait_idle();
    check("tdr_frames", di_log.size(), 5);
    for (int k = 0; k < 5 && k < di_log.size(); k++)
      check("tdr_di", di_log[k], 12'(12'h0F1 + k));

    // Reset in the 2nd FRAME cycle of a grant to requester 0.
    gnt_log.delete();
    @(posedge Clk); #1;
    set_fields(0, USR, 1'b0, 12'h000);
    set_fields(1, RDR, 1'b0, 12'h000);
    req[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge Clk);
      if (SSP_SSEL) got = 1;
    end
    if (!got) fail("rst_ssel_timeout");
    @(posedge Clk); #1;
    req[1] = 1'b1;
    Rst_n = 1'b0;
    #1;
    check("rst_async_drop", {SSP_SSEL, SSP_EOC, ack, busy}, 0);
    check("rst_async_state", dbg_state, IDLE);
    repeat (2) @(negedge Clk);
    gnt_log.delete();
    #1 Rst_n = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge Clk);
      if (ack != 0) got = 1;
    end
    if (!got) fail("rst_regrant_timeout");
    else check("rst_regrant_ack", ack, 2'b01);
    if (gnt_log.size() > 0) check("rst_first_grant", gnt_log[0], 0);
    else fail("rst_no_grant");
    @(posedge Clk); #1;
    req[0] = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge Clk);
      if (ack[1]) got = 1;
    end
    if (!got) fail("rst_req1_timeout");
    @(posedge Clk); #1;
    req[1] = 1'b0;
    wait_idle();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 2000; c++) begin
      @(posedge Clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          if ($urandom_range(0, 2) == 0) req[i] = 1'b0;
          else rand_fields(i);
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            rand_fields(i);
            req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          rand_fields(i);
        end
      end
    end
    // Let any outstanding request finish before dropping everything.
    for (int c = 0; c < 100 && req != 0; c++) begin
      @(posedge Clk); #1;
      for (int i = 0; i < NREQ; i++) if (ack[i]) req[i] = 1'b0;
    end
    if (req != 0) fail("drain_timeout");
    req = '0;
    wait_idle();
    repeat (3) @(negedge Clk);
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
